// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_unit                                              |
// | Description : Single-outstanding load/store initiator for a byte-banked    |
// |               32-bit memory without byte enables. Sub-word stores are done |
// |               as read-modify-write. Optional macro: MISALIGN_TRAP_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_raddress,
    output logic [ADDR_W-1:0] mem_waddress,
    output logic [31:0]       mem_datain,
    input  logic [31:0]       mem_dataout,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] c_cnt_last = 3'(MEM_RD_LAT);
    localparam logic [1:0] c_sz_byte  = 2'b00;
    localparam logic [1:0] c_sz_half  = 2'b01;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         old_q, old_d;

    logic                w_wr_phase;
    logic                w_resp_phase;
    logic [31:0]         w_merged;
    logic [31:0]         w_extract;

`ifdef MISALIGN_TRAP_EN
    logic                err_q, err_d;
    logic                w_misalign;

    assign w_misalign = ((req_size == c_sz_half) && req_addr[0])
                      || (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // Old word from the read phase supplies the bytes the store leaves untouched.
    always_comb begin
        w_merged = wdata_q;
        case (size_q)
            c_sz_byte: w_merged = {old_q[31:8],  wdata_q[7:0]};
            c_sz_half: w_merged = {old_q[31:16], wdata_q[15:0]};
            default:   w_merged = wdata_q;
        endcase
    end

    always_comb begin
        w_extract = old_q;
        case (size_q)
            c_sz_byte: w_extract = {{24{old_q[7]  & ~uns_q}}, old_q[7:0]};
            c_sz_half: w_extract = {{16{old_q[15] & ~uns_q}}, old_q[15:0]};
            default:   w_extract = old_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        old_d        = old_q;
`ifdef MISALIGN_TRAP_EN
        err_d        = err_q;
`endif
        req_ready    = 1'b0;
        w_wr_phase   = 1'b0;
        w_resp_phase = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                cnt_d     = 3'd0;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // Full-word stores need no old data, so they skip the read.
                    state_d = (req_we && req_size[1]) ? ST_WRITE : ST_READ;
`ifdef MISALIGN_TRAP_EN
                    err_d = w_misalign;
                    if (w_misalign) begin
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_READ: begin
                if (cnt_q == c_cnt_last) begin
                    old_d   = mem_dataout;
                    cnt_d   = 3'd0;
                    state_d = we_q ? ST_WRITE : ST_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WRITE: begin
                w_wr_phase = 1'b1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                w_resp_phase = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            old_q   <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // Reset also masks the strobes so an aborted access has no visible effect.
    assign mem_wr       = w_wr_phase & ~Reset;
    assign mem_datain   = w_wr_phase ? w_merged : 32'd0;
    assign resp_valid   = w_resp_phase & ~Reset;
    assign mem_raddress = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign mem_waddress = (state_q == ST_IDLE) ? req_addr : addr_q;

`ifdef MISALIGN_TRAP_EN
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? w_extract : 32'd0;
`else
    assign resp_err   = 1'b0;
    assign resp_rdata = (resp_valid && !we_q) ? w_extract : 32'd0;
`endif

endmodule
`default_nettype wire
